w_ptr_full_ctrl: RTL
====================

Name: w_ptr_full_ctrl

Overview:
Write-domain pointer and flag controller for the asynchronous FIFO. It holds the binary and Gray write pointers and generates a registered full flag and a registered fill level. It also generates a programmable almost-full flag and a sticky overflow flag. Inputs are the write request and the read pointer already synchronised into the write domain. Outputs drive the RAM write address and feed the read-domain synchroniser.

Parameters:
ADDR_WIDTH, 3, FIFO address bits; DEPTH = 2**ADDR_WIDTH; legal range >= 2.

Ports:
w_clk  input  1  write-domain clock.
w_rst_n  input  1  asynchronous active-low reset.
w_inc  input  1  write request for this cycle.
sync_gr_r_ptr  input  ADDR_WIDTH+1  Gray read pointer, already synchronised to w_clk.
af_thresh  input  ADDR_WIDTH+1  almost-full threshold in words, 0..DEPTH; quasi-static.
ovf_clr  input  1  clears the sticky overflow flag.
w_addr  output  ADDR_WIDTH  RAM write address, equal to w_bin[ADDR_WIDTH-1:0].
gr_w_ptr  output  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchroniser.
w_full  output  1  registered full flag.
w_almost_full  output  1  registered; high when level >= af_thresh.
w_level  output  ADDR_WIDTH+1  registered word count, 0..DEPTH.
w_overflow  output  1  sticky; high after a write is attempted while full.

Behaviour:
- Clock and reset: single clock w_clk. Reset is asynchronous, active-low, on w_rst_n.
- Reset values: w_bin=0, gr_w_ptr=0, w_full=0, w_almost_full=0, w_level=0, w_overflow=0. Reset asserted mid-operation clears all state immediately, independent of the clock.
- Write acceptance: w_wr = w_inc & ~w_full, using the registered w_full.
- Pointer update:
  - w_bin_next = w_bin + w_wr, modulo 2**(ADDR_WIDTH+1); wraps naturally.
  - gray_next = (w_bin_next >> 1) ^ w_bin_next.
  - On each edge, w_bin and gr_w_ptr take their _next values.
  - Exactly one bit of gr_w_ptr changes per accepted write. No glitching: gr_w_ptr comes directly from a flop.
- Full flag: w_full <= (gray_next == {~sync_gr_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1], sync_gr_r_ptr[ADDR_WIDTH-2:0]}).
  - It asserts on the same edge that accepts the DEPTH-th outstanding write, so there is zero-cycle lag for the writer.
  - Deassertion is pessimistic: it follows synchroniser latency.
- Level:
  - r_bin = Gray-to-binary of sync_gr_r_ptr.
  - w_level <= (w_bin_next - r_bin) modulo 2**(ADDR_WIDTH+1).
  - Recomputed every cycle, so it also changes on read-pointer movement with no write.
- Almost-full: w_almost_full <= (level_next >= af_thresh).
  - af_thresh=0 gives a constant 1 after the first edge out of reset.
  - af_thresh=DEPTH makes w_almost_full equal w_full.
- Overflow:
  - Set when w_inc & w_full; holds until ovf_clr.
  - Simultaneous set and ovf_clr: set wins.
  - A rejected write never moves the pointers.
- Simultaneous write and read-pointer change: both are applied in the same level_next and full computation; no priority is needed.
- Consistency invariants: w_full == (w_level == DEPTH) at all times; w_level never exceeds DEPTH.
- sync_gr_r_ptr must change by at most one Gray step per cycle, as guaranteed by the synchroniser. Larger jumps are out of spec.

Decomposition:
- Shared header (fifo_defs): ADDR_WIDTH default and the DEPTH derivation; reused by the read-side controller.
- One sub-module: gray2bin, a parametrised combinational Gray-to-binary converter with WIDTH=ADDR_WIDTH+1. The read-side level logic reuses it.
- Binary-to-Gray is inline logic.

Test Plan:
1. Reset, then 8 writes with sync_gr_r_ptr=0000 and af_thresh=6:
   - After write 6: w_almost_full=1, w_level=6.
   - After write 8: w_full=1, w_level=8, gr_w_ptr=1100, w_addr=000.
2. From full, hold w_inc=1 for 3 cycles:
   - gr_w_ptr stays 1100; w_overflow=1 and stays 1.
   - Pulse ovf_clr with w_inc=0: w_overflow=0 next edge.
   - ovf_clr and w_inc asserted together while full: w_overflow stays 1.
3. From full, step sync_gr_r_ptr 0000->0001->0011 (read pointer 2):
   - w_full=0 one edge after 0001 arrives.
   - w_level goes 8->7->6 with no writes.
   - w_almost_full stays 1 while level >= 6, then clears at level 5.
4. Continuous writes with sync_gr_r_ptr tracking gray(w_bin-2) for 20 cycles:
   - gr_w_ptr wraps 1000->0000 (binary 15->0).
   - w_level holds 2; w_full is never set.
   - Every pointer transition changes exactly one bit.
5. Drop w_rst_n asynchronously mid-write burst at level 5:
   - All outputs return to 0 without a clock edge.
   - First write after release gives gr_w_ptr=0001, w_level=1.
6. Bench invariant, checked every cycle across all scenarios, randomised ADDR_WIDTH in {2,3,4}:
   - w_full == (w_level == 2**ADDR_WIDTH).
   - w_level <= 2**ADDR_WIDTH.

Source files
------------

// File: rtl/w_ptr_full_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : w_ptr_full_ctrl_pkg                                        |
// | Description : Shared asynchronous-FIFO definitions (fifo_defs). Holds    |
// |               the default address width and the depth derivation, and  |
// |               is shared by the write-side and read-side controllers.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package w_ptr_full_ctrl_pkg;

   // Default FIFO address width. DEPTH = 2**ADDR_WIDTH words.
   localparam int C_ADDR_WIDTH = 3;

   // Smallest address width for which the full-flag Gray comparison is
   // meaningful. The comparison inverts the two top pointer bits and
   // keeps the rest, so at least two address bits are required.
   localparam int C_ADDR_WIDTH_MIN = 2;

   // FIFO depth in words for a given address width.
   function automatic int fifo_depth(input int addr_width);
      return 1 << addr_width;
   endfunction

endpackage : w_ptr_full_ctrl_pkg
`default_nettype wire

// File: rtl/w_ptr_full_ctrl_gray2bin.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gray2bin                                                   |
// | Description : Parametrised combinational Gray-to-binary converter.       |
// |               Binary bit i is the XOR reduction of Gray bits i..MSB.     |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   i_gray  in   WIDTH  Gray-coded value                                   |
// |   o_bin   out  WIDTH  equivalent binary value                            |
// +--------------------------------------------------------------------------+
module gray2bin
   import w_ptr_full_ctrl_pkg::*;
#(
   parameter int WIDTH = C_ADDR_WIDTH + 1
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   // Each output bit is independent, so a flat XOR-reduction per bit is
   // used instead of a ripple chain; synthesis balances the trees.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end

endmodule : gray2bin
`default_nettype wire

// File: rtl/w_ptr_full_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : w_ptr_full_ctrl                                            |
// | Description : Write-domain pointer and flag controller for an            |
// |               asynchronous FIFO. Keeps the binary and Gray write         |
// |               pointers and produces registered full, almost-full, fill   |
// |               level and a sticky overflow flag.                          |
// | Revision    : 1.0 - initial release                                      |
// |                                                                          |
// | Ports                                                                    |
// |   w_clk          in   1      write-domain clock                          |
// |   w_rst_n        in   1      asynchronous active-low reset               |
// |   w_inc          in   1      write request for this cycle                |
// |   sync_gr_r_ptr  in   AW+1   Gray read pointer, synchronised to w_clk    |
// |   af_thresh      in   AW+1   almost-full threshold, 0..DEPTH             |
// |   ovf_clr        in   1      clears the sticky overflow flag             |
// |   w_addr         out  AW     RAM write address                           |
// |   gr_w_ptr       out  AW+1   registered Gray write pointer               |
// |   w_full         out  1      registered full flag                        |
// |   w_almost_full  out  1      registered, level >= af_thresh              |
// |   w_level        out  AW+1   registered word count, 0..DEPTH             |
// |   w_overflow     out  1      sticky, write attempted while full          |
// +--------------------------------------------------------------------------+
module w_ptr_full_ctrl
   import w_ptr_full_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = C_ADDR_WIDTH
) (
   input  logic                  w_clk,
   input  logic                  w_rst_n,
   input  logic                  w_inc,
   input  logic [ADDR_WIDTH:0]   sync_gr_r_ptr,
   input  logic [ADDR_WIDTH:0]   af_thresh,
   input  logic                  ovf_clr,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH:0]   gr_w_ptr,
   output logic                  w_full,
   output logic                  w_almost_full,
   output logic [ADDR_WIDTH:0]   w_level,
   output logic                  w_overflow
);

   // ------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------
   logic [ADDR_WIDTH:0] r_w_bin;
   logic [ADDR_WIDTH:0] r_gr_w_ptr;
   logic                r_full;
   logic                r_almost_full;
   logic [ADDR_WIDTH:0] r_level;
   logic                r_overflow;

   // ------------------------------------------------------------------
   // Combinational next-state values
   // ------------------------------------------------------------------
   logic                w_wr;
   logic [ADDR_WIDTH:0] w_bin_next;
   logic [ADDR_WIDTH:0] w_gray_next;
   logic [ADDR_WIDTH:0] w_r_bin;
   logic [ADDR_WIDTH:0] w_full_pattern;
   logic [ADDR_WIDTH:0] w_level_next;
   logic                w_full_next;
   logic                w_almost_full_next;
   logic                w_overflow_next;

   // A write is only accepted while the registered full flag is clear,
   // so a rejected write can never move the pointers.
   assign w_wr = w_inc & ~r_full;

   // The extra MSB distinguishes full from empty; the add wraps
   // naturally modulo 2**(ADDR_WIDTH+1).
   assign w_bin_next  = r_w_bin + {{ADDR_WIDTH{1'b0}}, w_wr};
   assign w_gray_next = (w_bin_next >> 1) ^ w_bin_next;

   // Binary view of the synchronised read pointer, used for the level.
   gray2bin #(
      .WIDTH (ADDR_WIDTH + 1)
   ) u_gray2bin (
      .i_gray (sync_gr_r_ptr),
      .o_bin  (w_r_bin)
   );

   // In Gray code, a write pointer exactly DEPTH ahead of the read
   // pointer differs from it in the two top bits only. Comparing against
   // gray_next makes full assert on the very edge that accepts the last
   // free word. Release follows the read pointer through the
   // synchroniser, so it is late but never early.
   assign w_full_pattern = {~sync_gr_r_ptr[ADDR_WIDTH:ADDR_WIDTH-1],
                            sync_gr_r_ptr[ADDR_WIDTH-2:0]};
   assign w_full_next    = (w_gray_next == w_full_pattern);

   // Level is recomputed every cycle from both pointers, so it tracks
   // read-pointer movement even when no write happens. A concurrent
   // write and read-pointer step are both folded into this single
   // subtraction.
   assign w_level_next       = w_bin_next - w_r_bin;
   assign w_almost_full_next = (w_level_next >= af_thresh);

   // Sticky overflow: a write attempt while full sets it, and a set in
   // the same cycle as a clear takes priority so no event is lost.
   assign w_overflow_next = (w_inc & r_full) | (r_overflow & ~ovf_clr);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_w_bin       <= '0;
         r_gr_w_ptr    <= '0;
         r_full        <= 1'b0;
         r_almost_full <= 1'b0;
         r_level       <= '0;
         r_overflow    <= 1'b0;
      end else begin
         r_w_bin       <= w_bin_next;
         r_gr_w_ptr    <= w_gray_next;
         r_full        <= w_full_next;
         r_almost_full <= w_almost_full_next;
         r_level       <= w_level_next;
         r_overflow    <= w_overflow_next;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // The Gray pointer leaves straight from a flop so the read-domain
   // synchroniser never samples a combinational glitch.
   assign w_addr        = r_w_bin[ADDR_WIDTH-1:0];
   assign gr_w_ptr      = r_gr_w_ptr;
   assign w_full        = r_full;
   assign w_almost_full = r_almost_full;
   assign w_level       = r_level;
   assign w_overflow    = r_overflow;

endmodule : w_ptr_full_ctrl
`default_nettype wire
